// File: rtl/baccarat_pkg.sv
// Shared types and card-rule helpers for the Baccarat deal sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_SET4,
    S_DEC4,
    S_P3,
    S_SET3,
    S_DECB,
    S_D3,
    S_SETF,
    S_DONE
  } state_t;

  localparam int unsigned NATURAL_MIN      = 8;
  localparam int unsigned PLAYER_STAND_MIN = 6;
  localparam int unsigned BANKER_STAND_MIN = 7;

  // Ten and face cards count as zero.
  function automatic int unsigned card_value(input int unsigned raw);
    return (raw >= 32'd10) ? 32'd0 : raw;
  endfunction

  // Banker tableau once the player has taken a third card of value v.
  function automatic logic banker_draws(input int unsigned dscore, input int unsigned v);
    logic d;
    if (dscore >= BANKER_STAND_MIN) begin
      d = 1'b0;
    end else begin
      case (dscore)
        32'd0, 32'd1, 32'd2: d = 1'b1;
        32'd3:               d = (v != 32'd8);
        32'd4:               d = (v >= 32'd2) && (v <= 32'd7);
        32'd5:               d = (v >= 32'd4) && (v <= 32'd7);
        32'd6:               d = (v >= 32'd6) && (v <= 32'd7);
        default:             d = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/baccarat_deal_ctrl_if.sv
// Handshake bundle between the deal sequencer and the Baccarat datapath.
interface baccarat_deal_ctrl_if #(
  parameter int unsigned CARD_W = 4
);
  logic              step;
  logic [CARD_W-1:0] pscore;
  logic [CARD_W-1:0] dscore;
  logic [CARD_W-1:0] pcard3;
  logic              load_pcard1;
  logic              load_pcard2;
  logic              load_pcard3;
  logic              load_dcard1;
  logic              load_dcard2;
  logic              load_dcard3;
  logic              done;
  logic              player_win;
  logic              dealer_win;

  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  done, player_win, dealer_win
  );

  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output done, player_win, dealer_win
  );
endinterface

// File: rtl/baccarat_draw_rules.sv
// Combinational Baccarat rule evaluation on the current datapath scores.
module baccarat_draw_rules
  import baccarat_pkg::*;
#(
  parameter int unsigned CARD_W = 4
) (
  input  logic [CARD_W-1:0] pscore_i,
  input  logic [CARD_W-1:0] dscore_i,
  input  logic [CARD_W-1:0] pcard3_i,
  output logic              player_draw_o,
  output logic              banker_draw_no_p3_o,
  output logic              banker_draw_with_p3_o,
  output logic              natural_o
);

  int unsigned ps, ds, v;

  always_comb begin
    ps = 32'(pscore_i);
    ds = 32'(dscore_i);
    v  = card_value(32'(pcard3_i));
    natural_o             = (ps >= NATURAL_MIN) || (ds >= NATURAL_MIN);
    player_draw_o         = (ps < PLAYER_STAND_MIN);
    // With the player standing, the banker follows the player's own 0..5 rule.
    banker_draw_no_p3_o   = (ds < PLAYER_STAND_MIN);
    banker_draw_with_p3_o = banker_draws(ds, v);
  end

endmodule

// File: rtl/baccarat_deal_ctrl.sv
// Deal sequencer: one step deals one card, applies draw rules, latches the winner.
module baccarat_deal_ctrl
  import baccarat_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CARD_W        = 4
) (
  input  logic                 clock,
  input  logic                 resetb,
  baccarat_deal_ctrl_if.slave  bus
);

  localparam int unsigned     CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  // Strobe vector bit positions.
  localparam int unsigned LD_P1 = 0;
  localparam int unsigned LD_D1 = 1;
  localparam int unsigned LD_P2 = 2;
  localparam int unsigned LD_D2 = 3;
  localparam int unsigned LD_P3 = 4;
  localparam int unsigned LD_D3 = 5;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       load_q, load_d;
  logic             done_q, done_d;
  logic             pwin_q, pwin_d;
  logic             dwin_q, dwin_d;
  logic             finish;

  logic player_draw, banker_draw_no_p3, banker_draw_with_p3, natural;

  baccarat_draw_rules #(
    .CARD_W(CARD_W)
  ) u_rules (
    .pscore_i              (bus.pscore),
    .dscore_i              (bus.dscore),
    .pcard3_i              (bus.pcard3),
    .player_draw_o         (player_draw),
    .banker_draw_no_p3_o   (banker_draw_no_p3),
    .banker_draw_with_p3_o (banker_draw_with_p3),
    .natural_o             (natural)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = '0;
    done_d  = done_q;
    pwin_d  = pwin_q;
    dwin_d  = dwin_q;
    finish  = 1'b0;

    unique case (state_q)
      S_P1: if (bus.step) begin load_d[LD_P1] = 1'b1; state_d = S_D1; end
      S_D1: if (bus.step) begin load_d[LD_D1] = 1'b1; state_d = S_P2; end
      S_P2: if (bus.step) begin load_d[LD_P2] = 1'b1; state_d = S_D2; end
      S_D2: if (bus.step) begin
        load_d[LD_D2] = 1'b1;
        cnt_d         = SETTLE_LD;
        state_d       = S_SET4;
      end
      S_SET4: if (cnt_q == '0) state_d = S_DEC4; else cnt_d = cnt_q - 1'b1;
      S_DEC4: begin
        if (natural)                finish  = 1'b1;
        else if (player_draw)       state_d = S_P3;
        else if (banker_draw_no_p3) state_d = S_D3;
        else                        finish  = 1'b1;
      end
      S_P3: if (bus.step) begin
        load_d[LD_P3] = 1'b1;
        cnt_d         = SETTLE_LD;
        state_d       = S_SET3;
      end
      S_SET3: if (cnt_q == '0) state_d = S_DECB; else cnt_d = cnt_q - 1'b1;
      S_DECB: if (banker_draw_with_p3) state_d = S_D3; else finish = 1'b1;
      S_D3: if (bus.step) begin
        load_d[LD_D3] = 1'b1;
        cnt_d         = SETTLE_LD;
        state_d       = S_SETF;
      end
      S_SETF: if (cnt_q == '0) finish = 1'b1; else cnt_d = cnt_q - 1'b1;
      S_DONE: ;
      default: state_d = S_P1;
    endcase

    // Winner is captured once, on the edge that enters S_DONE.
    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      pwin_d  = (bus.pscore >= bus.dscore);
      dwin_d  = (bus.dscore >= bus.pscore);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      state_q <= S_P1;
      cnt_q   <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      done_q  <= done_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  assign bus.load_pcard1 = load_q[LD_P1];
  assign bus.load_dcard1 = load_q[LD_D1];
  assign bus.load_pcard2 = load_q[LD_P2];
  assign bus.load_dcard2 = load_q[LD_D2];
  assign bus.load_pcard3 = load_q[LD_P3];
  assign bus.load_dcard3 = load_q[LD_D3];
  assign bus.done        = done_q;
  assign bus.player_win  = pwin_q;
  assign bus.dealer_win  = dwin_q;

endmodule

// File: tb/tb_baccarat_deal_ctrl.sv
// Directed bench for baccarat_deal_ctrl: deal order, draw rules, reset, step dropping.
module tb_baccarat_deal_ctrl;

  localparam logic [5:0] L_P1 = 6'b000001;
  localparam logic [5:0] L_D1 = 6'b000010;
  localparam logic [5:0] L_P2 = 6'b000100;
  localparam logic [5:0] L_D2 = 6'b001000;
  localparam logic [5:0] L_P3 = 6'b010000;
  localparam logic [5:0] L_D3 = 6'b100000;

  logic clock;
  logic resetb;

  baccarat_deal_ctrl_if #(.CARD_W(4)) bus1 ();
  baccarat_deal_ctrl_if #(.CARD_W(4)) bus3 ();

  baccarat_deal_ctrl #(.SETTLE_CYCLES(1), .CARD_W(4)) u_dut (
    .clock(clock), .resetb(resetb), .bus(bus1.slave)
  );
  baccarat_deal_ctrl #(.SETTLE_CYCLES(3), .CARD_W(4)) u_dut3 (
    .clock(clock), .resetb(resetb), .bus(bus3.slave)
  );

  // The slow-settle instance sees exactly the same stimulus.
  assign bus3.step   = bus1.step;
  assign bus3.pscore = bus1.pscore;
  assign bus3.dscore = bus1.dscore;
  assign bus3.pcard3 = bus1.pcard3;

  logic [5:0] ld1, ld3;
  assign ld1 = {bus1.load_dcard3, bus1.load_pcard3, bus1.load_dcard2,
                bus1.load_pcard2, bus1.load_dcard1, bus1.load_pcard1};
  assign ld3 = {bus3.load_dcard3, bus3.load_pcard3, bus3.load_dcard2,
                bus3.load_pcard2, bus3.load_dcard1, bus3.load_pcard1};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned pulses1 [6];
  int unsigned pulses3 [6];
  int unsigned overlap = 0;

  always @(negedge clock) begin
    if (!resetb) begin
      for (int i = 0; i < 6; i++) begin
        pulses1[i] = 0;
        pulses3[i] = 0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (ld1[i]) pulses1[i]++;
        if (ld3[i]) pulses3[i]++;
      end
      if ($countones(ld1) > 1 || $countones(ld3) > 1) overlap++;
    end
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    resetb    = 1'b0;
    bus1.step = 1'b1;
    @(posedge clock); #1;
    check({tag, "_rst"}, 32'({ld1, bus1.done, bus1.player_win, bus1.dealer_win}), 0);
    @(posedge clock); #1;
    @(negedge clock);
    resetb    = 1'b1;
    bus1.step = 1'b0;
  endtask

  // One step; expect the given strobe for exactly one cycle.
  task automatic step_expect(input string tag, input logic [5:0] exp);
    @(negedge clock);
    bus1.step = 1'b1;
    @(posedge clock); #1;
    check({tag, "_ld"}, 32'(ld1), 32'(exp));
    @(negedge clock);
    bus1.step = 1'b0;
    @(posedge clock); #1;
    check({tag, "_w"}, 32'(ld1), 0);
  endtask

  task automatic deal4(input string tag);
    step_expect({tag, "_p1"}, L_P1); wait_cyc(3);
    step_expect({tag, "_d1"}, L_D1); wait_cyc(3);
    step_expect({tag, "_p2"}, L_P2); wait_cyc(3);
    step_expect({tag, "_d2"}, L_D2);
    check({tag, "_busy"}, 32'(bus1.done), 0);
  endtask

  int unsigned t4_d   [8] = '{3, 3, 4, 4, 5, 5, 6, 6};
  int unsigned t4_p   [8] = '{12, 8, 1, 2, 3, 4, 5, 6};
  int unsigned t4_drw [8] = '{1, 0, 0, 1, 0, 1, 0, 1};

  initial begin
    resetb      = 1'b0;
    bus1.step   = 1'b0;
    bus1.pscore = 4'd0;
    bus1.dscore = 4'd0;
    bus1.pcard3 = 4'd0;

    // Natural player 8 vs 3
    do_reset("t1");
    bus1.pscore = 4'd8; bus1.dscore = 4'd3;
    deal4("t1");
    wait_cyc(4);
    check("t1_done", 32'(bus1.done), 1);
    check("t1_pwin", 32'(bus1.player_win), 1);
    check("t1_dwin", 32'(bus1.dealer_win), 0);
    check("t1_np3", pulses1[4], 0);
    check("t1_nd3", pulses1[5], 0);

    // Player draws 5, banker on 5 draws, tie 7-7
    do_reset("t2");
    bus1.pscore = 4'd4; bus1.dscore = 4'd5; bus1.pcard3 = 4'd5;
    deal4("t2");
    wait_cyc(4);
    step_expect("t2_p3", L_P3);
    wait_cyc(4);
    check("t2_busy3", 32'(bus1.done), 0);
    bus1.pscore = 4'd7; bus1.dscore = 4'd7;
    step_expect("t2_d3", L_D3);
    wait_cyc(5);
    check("t2_done", 32'(bus1.done), 1);
    check("t2_pwin", 32'(bus1.player_win), 1);
    check("t2_dwin", 32'(bus1.dealer_win), 1);

    // Player stands on 6, banker 4 draws directly, banker wins 9 vs 6
    do_reset("t3");
    bus1.pscore = 4'd6; bus1.dscore = 4'd4; bus1.pcard3 = 4'd0;
    deal4("t3");
    wait_cyc(4);
    check("t3_busy", 32'(bus1.done), 0);
    bus1.dscore = 4'd9;
    step_expect("t3_d3", L_D3);
    wait_cyc(5);
    check("t3_np3", pulses1[4], 0);
    check("t3_done", 32'(bus1.done), 1);
    check("t3_pwin", 32'(bus1.player_win), 0);
    check("t3_dwin", 32'(bus1.dealer_win), 1);

    // Banker tableau edges after a player third card
    for (int k = 0; k < 8; k++) begin
      do_reset($sformatf("t4_%0d", k));
      bus1.pscore = 4'd3;
      bus1.dscore = 4'(t4_d[k]);
      bus1.pcard3 = 4'(t4_p[k]);
      deal4($sformatf("t4_%0d", k));
      wait_cyc(4);
      step_expect($sformatf("t4_%0d_p3", k), L_P3);
      wait_cyc(4);
      check($sformatf("t4_%0d_dec", k), 32'(bus1.done), (t4_drw[k] != 0) ? 0 : 1);
      step_expect($sformatf("t4_%0d_d3", k), (t4_drw[k] != 0) ? L_D3 : 6'b0);
      wait_cyc(5);
      check($sformatf("t4_%0d_fin", k), 32'(bus1.done), 1);
      check($sformatf("t4_%0d_nd3", k), pulses1[5], t4_drw[k]);
    end

    // Reset mid-hand, right after the pcard3 strobe
    do_reset("t5");
    bus1.pscore = 4'd2; bus1.dscore = 4'd2; bus1.pcard3 = 4'd1;
    deal4("t5");
    wait_cyc(4);
    step_expect("t5_p3", L_P3);
    @(negedge clock);
    resetb = 1'b0;
    @(posedge clock); #1;
    check("t5_abort", 32'({ld1, bus1.done, bus1.player_win, bus1.dealer_win}), 0);
    @(negedge clock);
    resetb = 1'b1;
    step_expect("t5_p1", L_P1);

    // Back-to-back steps at D2; settle length 1 vs 3
    do_reset("t6");
    bus1.pscore = 4'd9; bus1.dscore = 4'd9;
    step_expect("t6_p1", L_P1); wait_cyc(3);
    step_expect("t6_d1", L_D1); wait_cyc(3);
    step_expect("t6_p2", L_P2); wait_cyc(3);
    @(negedge clock);
    bus1.step = 1'b1;
    @(posedge clock); #1;
    check("t6_d2_s1", 32'(ld1), 32'(L_D2));
    check("t6_d2_s3", 32'(ld3), 32'(L_D2));
    @(posedge clock); #1;
    check("t6_drop_s1", 32'(ld1), 0);
    check("t6_drop_s3", 32'(ld3), 0);
    @(negedge clock);
    bus1.step = 1'b0;
    @(posedge clock); #1;
    check("t6_s1_early", 32'(bus1.done), 0);
    @(posedge clock); #1;
    check("t6_s1_done", 32'(bus1.done), 1);
    check("t6_s3_wait1", 32'(bus3.done), 0);
    @(posedge clock); #1;
    check("t6_s3_wait2", 32'(bus3.done), 0);
    @(posedge clock); #1;
    check("t6_s3_done", 32'(bus3.done), 1);
    check("t6_s3_tie", 32'({bus3.player_win, bus3.dealer_win}), 3);
    check("t6_s1_nd2", pulses1[3], 1);
    check("t6_s3_nd2", pulses3[3], 1);
    check("t6_s1_nextra", pulses1[4] + pulses1[5], 0);

    check("overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
